// File: rtl/axis_video_rx.sv
// AXI4-Stream UYVY video sink: checks frame geometry and packs 4 luma samples per 32-bit word.
// Optional VRX_ERR_COUNT_EN adds a saturating err_cnt output counting err_sof/err_eol pulses.
module axis_video_rx #(
  parameter int WDT = 640,
  parameter int HGT = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        s_tuser,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic [15:0] s_tdata,
  input  logic        s_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [31:0] m_tdata,
  output logic        m_tuser,
  output logic        m_tlast,
  output logic        frame_done,
  output logic        err_sof,
`ifdef VRX_ERR_COUNT_EN
  output logic        err_eol,
  output logic [15:0] err_cnt
`else
  output logic        err_eol
`endif
);

  // Both streams use valid/ready: a transfer happens on a rising clk edge where valid & ready are
  // high; a source holds its payload stable while valid is high and ready is low.

  localparam logic [0:0] WAIT_SOF = 1'b0;
  localparam logic [0:0] ACTIVE   = 1'b1;

  localparam logic [15:0] COL_LAST = 16'(WDT - 1);
  localparam logic [15:0] ROW_LAST = 16'(HGT - 1);

  logic [0:0]  state;
  logic [15:0] col;
  logic [15:0] row;
  logic [23:0] pack;
  logic [1:0]  lane;
  logic [7:0]  y;
  logic        active;
  logic        slot_free;
  logic        beat;
  logic        at_eol;
  logic        sof_hit;
  logic        eol_bad;
  logic        good;
  logic        frame_end;
  logic        unused_chroma;

  assign unused_chroma = ^s_tdata[7:0];

  // WDT is a multiple of 4, so the pack lane is simply the low bits of the column.
  assign lane      = col[1:0];
  assign y         = s_tdata[15:8];
  assign active    = (state == ACTIVE);
  assign slot_free = ~m_tvalid | m_tready;
  assign s_tready  = rst_n & en & (active ? ((lane != 2'd3) | slot_free) : slot_free);
  assign beat      = s_tvalid & s_tready;
  assign at_eol    = (col == COL_LAST);
  assign sof_hit   = beat & s_tuser;
  assign eol_bad   = beat & active & ~s_tuser & (at_eol != s_tlast);
  assign good      = beat & active & ~s_tuser & (at_eol == s_tlast);
  assign frame_end = good & at_eol & (row == ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_SOF;
      col        <= 16'd0;
      row        <= 16'd0;
      pack       <= 24'd0;
      m_tvalid   <= 1'b0;
      m_tdata    <= 32'd0;
      m_tuser    <= 1'b0;
      m_tlast    <= 1'b0;
      frame_done <= 1'b0;
      err_sof    <= 1'b0;
      err_eol    <= 1'b0;
    end else begin
      frame_done <= frame_end;
      err_sof    <= sof_hit & active;
      err_eol    <= eol_bad;

      if (m_tvalid && m_tready) begin
        m_tvalid <= 1'b0;
      end
      if (good && (lane == 2'd3)) begin
        m_tvalid <= 1'b1;
        m_tdata  <= {y, pack};
        m_tuser  <= (row == 16'd0) && (col == 16'd3);
        m_tlast  <= at_eol;
      end

      // A tuser beat always restarts the frame, even mid-frame; the pending pack is overwritten.
      if (!en) begin
        state <= WAIT_SOF;
        col   <= 16'd0;
        row   <= 16'd0;
      end else if (sof_hit) begin
        state <= ACTIVE;
        col   <= 16'd1;
        row   <= 16'd0;
        pack  <= {16'd0, y};
      end else if (eol_bad) begin
        state <= WAIT_SOF;
        col   <= 16'd0;
        row   <= 16'd0;
      end else if (good) begin
        case (lane)
          2'd0:    pack[7:0]   <= y;
          2'd1:    pack[15:8]  <= y;
          2'd2:    pack[23:16] <= y;
          default: pack        <= pack;
        endcase
        if (at_eol) begin
          col <= 16'd0;
          if (row == ROW_LAST) begin
            row   <= 16'd0;
            state <= WAIT_SOF;
          end else begin
            row <= row + 16'd1;
          end
        end else begin
          col <= col + 16'd1;
        end
      end
    end
  end

`ifdef VRX_ERR_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 16'd0;
    end else if (((sof_hit & active) | eol_bad) && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_video_rx.sv
// Directed bench for axis_video_rx with WDT=8, HGT=2: clean frames, back-pressure, geometry errors, reset.
module tb_axis_video_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        s_tuser = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [15:0] s_tdata = 16'd0;
  logic        s_tlast = 1'b0;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [31:0] m_tdata;
  logic        m_tuser;
  logic        m_tlast;
  logic        frame_done;
  logic        err_sof;
  logic        err_eol;
`ifdef VRX_ERR_COUNT_EN
  logic [15:0] err_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;
  int sof_cnt = 0;
  int eol_cnt = 0;
  int words_seen = 0;
  int stall_cnt = 0;

  logic [33:0] exp_q[$];
  logic        prev_hold = 1'b0;
  logic [33:0] prev_word = 34'd0;

  axis_video_rx #(.WDT(8), .HGT(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .s_tuser    (s_tuser),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tdata    (s_tdata),
    .s_tlast    (s_tlast),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tuser    (m_tuser),
    .m_tlast    (m_tlast),
    .frame_done (frame_done),
    .err_sof    (err_sof),
`ifdef VRX_ERR_COUNT_EN
    .err_eol    (err_eol),
    .err_cnt    (err_cnt)
`else
    .err_eol    (err_eol)
`endif
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard / monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (frame_done) fd_cnt++;
      if (err_sof) sof_cnt++;
      if (err_eol) eol_cnt++;
      if (prev_hold) begin
        chk("hold_stable", {m_tvalid, m_tuser, m_tlast, m_tdata}, {1'b1, prev_word});
      end
      if (m_tvalid && m_tready) begin
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("word", {m_tuser, m_tlast, m_tdata}, exp_q.pop_front());
        end
        words_seen++;
      end
      prev_hold = m_tvalid & ~m_tready;
      prev_word = {m_tuser, m_tlast, m_tdata};
    end
  end

  // Driver tasks
  task automatic send_beat(input logic [7:0] y, input logic u, input logic l, input int idx);
    int   n;
    logic acc;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = {y, 8'h5A};
    s_tuser  = u;
    s_tlast  = l;
    do begin
      @(negedge clk);
      acc = s_tready;
      if (!acc) begin
        stall_cnt++;
        chk("stall_only_lane3", idx % 4, 3);
      end
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("beat_timeout", 0, 1);
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] base);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 8; c++) begin
        send_beat(base + 8'(r * 8 + c), (r == 0) && (c == 0), c == 7, c);
      end
    end
  endtask

  // {tuser, tlast, data} of the clean frame with Y = 0..15
  task automatic exp_clean();
    exp_q.push_back({2'b10, 32'h03020100});
    exp_q.push_back({2'b01, 32'h07060504});
    exp_q.push_back({2'b00, 32'h0B0A0908});
    exp_q.push_back({2'b01, 32'h0F0E0D0C});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    // Reset
    #2;
    chk("reset_outputs", {s_tready, m_tvalid, m_tdata, m_tuser, m_tlast, frame_done, err_sof, err_eol}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("en_low_not_ready", s_tready, 0);
    en = 1'b1;
    #1;
    chk("en_high_ready", s_tready, 1);
    @(posedge clk);
    #1;

    // Test 1: clean frame
    exp_clean();
    send_frame(8'h00);
    drain();
    chk("t1_frame_done", fd_cnt, 1);
    chk("t1_no_err", sof_cnt + eol_cnt, 0);

    // Test 2: downstream stall after the first word
    exp_clean();
    words_seen = 0;
    stall_cnt = 0;
    fork
      send_frame(8'h00);
      begin
        int n;
        n = 0;
        while (words_seen < 1 && n < 500) begin
          @(posedge clk);
          n++;
        end
        #1 m_tready = 1'b0;
        repeat (20) @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join
    drain();
    chk("t2_stalled", stall_cnt > 0, 1);
    chk("t2_words", words_seen, 4);
    chk("t2_frame_done", fd_cnt, 2);

    // Test 3: beats before SOF are dropped
    send_beat(8'hE0, 1'b0, 1'b0, 0);
    send_beat(8'hE1, 1'b0, 1'b1, 0);
    send_beat(8'hE2, 1'b0, 1'b0, 0);
    exp_clean();
    send_frame(8'h00);
    drain();
    chk("t3_frame_done", fd_cnt, 3);
    chk("t3_no_err", sof_cnt + eol_cnt, 0);

    // Test 4: early tlast at col 5 of row 0
    exp_q.push_back({2'b10, 32'h03020100});
    for (int c = 0; c < 6; c++) begin
      send_beat(8'(c), c == 0, c == 5, c);
    end
    for (int c = 0; c < 4; c++) begin
      send_beat(8'(8'h40 + c), 1'b0, 1'b0, c);
    end
    drain();
    chk("t4_err_eol", eol_cnt, 1);
    chk("t4_no_sof_err", sof_cnt, 0);
    chk("t4_frame_done", fd_cnt, 3);
`ifdef VRX_ERR_COUNT_EN
    chk("t4_err_cnt", err_cnt, 1);
`endif

    // Test 5: tuser at col 3 of row 1 restarts the frame
    exp_q.push_back({2'b10, 32'h03020100});
    exp_q.push_back({2'b01, 32'h07060504});
    exp_q.push_back({2'b10, 32'h23222120});
    exp_q.push_back({2'b01, 32'h27262524});
    exp_q.push_back({2'b00, 32'h2B2A2928});
    exp_q.push_back({2'b01, 32'h2F2E2D2C});
    for (int c = 0; c < 8; c++) begin
      send_beat(8'(c), c == 0, c == 7, c);
    end
    for (int c = 0; c < 3; c++) begin
      send_beat(8'(8 + c), 1'b0, 1'b0, c);
    end
    send_frame(8'h20);
    drain();
    chk("t5_err_sof", sof_cnt, 1);
    chk("t5_err_eol", eol_cnt, 1);
    chk("t5_frame_done", fd_cnt, 4);
`ifdef VRX_ERR_COUNT_EN
    chk("t5_err_cnt", err_cnt, 2);
`endif

    // Test 6: reset mid row 1 with a word held at the output
    exp_q.push_back({2'b10, 32'h03020100});
    for (int c = 0; c < 4; c++) begin
      send_beat(8'(c), c == 0, 1'b0, c);
    end
    m_tready = 1'b0;
    for (int c = 4; c < 8; c++) begin
      send_beat(8'(c), 1'b0, c == 7, c);
    end
    for (int c = 0; c < 3; c++) begin
      send_beat(8'(8 + c), 1'b0, 1'b0, c);
    end
    chk("t6_q_before_reset", exp_q.size(), 0);
    chk("t6_word_held", {m_tvalid, m_tuser, m_tlast, m_tdata}, {3'b101, 32'h07060504});
    rst_n = 1'b0;
    #1;
    chk("t6_reset_outputs", {s_tready, m_tvalid, m_tdata, m_tuser, m_tlast, frame_done, err_sof, err_eol}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    exp_clean();
    send_frame(8'h00);
    drain();
    chk("t6_frame_done", fd_cnt, 5);
    chk("t6_err_totals", sof_cnt + eol_cnt, 2);
`ifdef VRX_ERR_COUNT_EN
    chk("t6_err_cnt_cleared", err_cnt, 0);
`endif

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
